// File: rtl/hls_mem_pkg.sv
// Shared limits and helpers for the HLS multiport memory.
package hls_mem_pkg;

    localparam int MAX_RD = 4;
    localparam int MAX_WR = 2;

    // Low bit of field idx in a flat bus of w-bit fields.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    // Addresses at or above depth are silently dropped (writes) or read as zero.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/multiport_ram_param_delay_pipe.sv
// Fixed-length delay line with a resettable valid bit; DEPTH=0 is a wire.
module delay_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_thru
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_pipe
            logic [DEPTH-1:0] valid_q;
            logic [WIDTH-1:0] data_q [DEPTH];

            // Valid bits clear on reset so in-flight writes are dropped.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= '0;
                end else begin
                    valid_q[0] <= in_valid;
                    for (int s = 1; s < DEPTH; s++) valid_q[s] <= valid_q[s-1];
                end
            end

            // Payload only matters when its valid bit is set, so it needs no reset.
            always_ff @(posedge clk) begin
                data_q[0] <= in_data;
                for (int s = 1; s < DEPTH; s++) data_q[s] <= data_q[s-1];
            end

            assign out_valid = valid_q[DEPTH-1];
            assign out_data  = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/multiport_ram_param.sv
// Multiport RAM with delayed write commit, registered reads, optional
// same-edge forwarding, a debug port and a sticky write-collision flag.
module multiport_ram_param
    import hls_mem_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int WR_DELAY   = 1,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    input  logic [NUM_RD-1:0]        ren,
    output logic [NUM_RD*WIDTH-1:0]  rdata,
    output logic [NUM_RD-1:0]        rvalid,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*WIDTH-1:0]  wdata,
    input  logic [NUM_WR-1:0]        wen,
    input  logic [ADDR_W-1:0]        debug_addr,
    output logic [WIDTH-1:0]         debug_data,
    input  logic [ADDR_W-1:0]        debug_write_addr,
    input  logic [WIDTH-1:0]         debug_write_data,
    input  logic                     debug_write_en,
    output logic                     wr_conflict
);

    localparam int PW   = ADDR_W + WIDTH;
    // Commit sources in ascending priority; the debug write is the last (highest).
    localparam int NSRC = NUM_WR + 1;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              pipe_valid [NUM_WR];
    logic [ADDR_W-1:0] pipe_addr  [NUM_WR];
    logic [WIDTH-1:0]  pipe_data  [NUM_WR];

    logic              src_en   [NSRC];
    logic [ADDR_W-1:0] src_addr [NSRC];
    logic [WIDTH-1:0]  src_data [NSRC];

    logic                    conflict_now;
    logic [NUM_RD*WIDTH-1:0] rd_word;
    logic [NUM_RD*WIDTH-1:0] s1_data;
    logic [NUM_RD-1:0]       s1_valid;

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        logic [PW-1:0] out_pl;

        delay_pipe #(.WIDTH(PW), .DEPTH(WR_DELAY)) u_pipe (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (wen[p]),
            .in_data   ({waddr[slice_lo(p, ADDR_W) +: ADDR_W], wdata[slice_lo(p, WIDTH) +: WIDTH]}),
            .out_valid (pipe_valid[p]),
            .out_data  (out_pl)
        );

        assign pipe_addr[p] = out_pl[PW-1 -: ADDR_W];
        assign pipe_data[p] = out_pl[WIDTH-1:0];
    end

    // Gather everything committing on the coming edge; out-of-range targets never commit.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            src_en[p]   = pipe_valid[p] && addr_in_range(32'(pipe_addr[p]), DEPTH);
            src_addr[p] = pipe_addr[p];
            src_data[p] = pipe_data[p];
        end
        src_en[NUM_WR]   = debug_write_en && addr_in_range(32'(debug_write_addr), DEPTH);
        src_addr[NUM_WR] = debug_write_addr;
        src_data[NUM_WR] = debug_write_data;
    end

    // Any two committing sources on the same word this edge is a collision.
    always_comb begin
        conflict_now = 1'b0;
        for (int a = 0; a < NSRC; a++) begin
            for (int b = a + 1; b < NSRC; b++) begin
                if (src_en[a] && src_en[b] && (src_addr[a] == src_addr[b])) conflict_now = 1'b1;
            end
        end
    end

    // Later sources overwrite earlier ones, giving the debug write top priority.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (src_en[s]) mem[src_addr[s]] <= src_data[s];
        end
    end

    // Sticky collision flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_conflict <= 1'b0;
        else if (conflict_now) wr_conflict <= 1'b1;
    end

    // Array word per read port, optionally replaced by the winning same-edge commit.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (addr_in_range(32'(raddr[slice_lo(i, ADDR_W) +: ADDR_W]), DEPTH)) begin
                rd_word[slice_lo(i, WIDTH) +: WIDTH] = mem[raddr[slice_lo(i, ADDR_W) +: ADDR_W]];
                if (BYPASS != 0) begin
                    for (int s = 0; s < NSRC; s++) begin
                        if (src_en[s] && (src_addr[s] == raddr[slice_lo(i, ADDR_W) +: ADDR_W]))
                            rd_word[slice_lo(i, WIDTH) +: WIDTH] = src_data[s];
                    end
                end
            end
        end
    end

    // First read register: captures on ren, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= '0;
        end else begin
            s1_valid <= ren;
            for (int i = 0; i < NUM_RD; i++) begin
                if (ren[i]) s1_data[slice_lo(i, WIDTH) +: WIDTH] <= rd_word[slice_lo(i, WIDTH) +: WIDTH];
            end
        end
    end

    generate
        if (RD_LATENCY >= 2) begin : g_lat2
            // Second read register: follows the first, holding when nothing new arrived.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata  <= '0;
                    rvalid <= '0;
                end else begin
                    rvalid <= s1_valid;
                    for (int i = 0; i < NUM_RD; i++) begin
                        if (s1_valid[i]) rdata[slice_lo(i, WIDTH) +: WIDTH] <= s1_data[slice_lo(i, WIDTH) +: WIDTH];
                    end
                end
            end
        end else begin : g_lat1
            assign rdata  = s1_data;
            assign rvalid = s1_valid;
        end
    endgenerate

    assign debug_data = addr_in_range(32'(debug_addr), DEPTH) ? mem[debug_addr] : '0;

endmodule
